// File: rtl/quad_sum_sequencer.sv
// Steps the 4:1 mux selects through A0..A3 and sums the masked operands; done pulses 4 cycles after start is accepted.
// No backpressure: start is only sampled in IDLE, so requests arriving mid-run are dropped, not queued.
module quad_sum_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         mask,
  input  logic [WIDTH-1:0]   Y,
  output logic               S0,
  output logic               S1,
  output logic [WIDTH+1:0]   sum,
  output logic               busy,
  output logic               done
);

  localparam int SUM_WIDTH = WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           idx;
  logic [3:0]           mask_q;
  logic [SUM_WIDTH-1:0] acc;
  logic [SUM_WIDTH-1:0] acc_nxt;

  // Y is valid combinationally for the select driven from the registered idx
  assign acc_nxt = acc + (mask_q[idx] ? SUM_WIDTH'(Y) : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ACC;
      ST_ACC:  if (idx == 2'd3) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      acc    <= '0;
      mask_q <= '0;
      sum    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx    <= '0;
            acc    <= '0;
            mask_q <= mask;
          end
        end
        ST_ACC: begin
          acc <= acc_nxt;
          idx <= idx + 2'd1;
          if (idx == 2'd3) sum <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    {S1, S0} = 2'b00;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_ACC: begin
        {S1, S0} = idx;
        busy     = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_quad_sum_sequencer.sv
// Directed bench for quad_sum_sequencer; a behavioural mux feeds Y from the a[] operand array.
module tb_quad_sum_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] mask;
  logic [7:0] Y;
  logic       S0, S1;
  logic [9:0] sum;
  logic       busy, done;

  logic [7:0] a [4];
  int         sb_q[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  always_comb Y = a[{S1, S0}];

  quad_sum_sequencer #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mask  (mask),
    .Y     (Y),
    .S0    (S0),
    .S1    (S1),
    .sum   (sum),
    .busy  (busy),
    .done  (done)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int a0, input int a1, input int a2, input int a3);
    a[0] = 8'(a0); a[1] = 8'(a1); a[2] = 8'(a2); a[3] = 8'(a3);
  endtask

  // Reference sum for a masked run; pushed to the scoreboard when the run is requested
  function automatic int ref_sum(input logic [3:0] m);
    int s = 0;
    for (int i = 0; i < 4; i++) if (m[i]) s += int'(a[i]);
    return s;
  endfunction

  // Waits for a done pulse, returns the number of cycles it took, pops and compares the sum
  task automatic wait_done(input string tag, output int cycles);
    int exp;
    cycles = 0;
    while (!done && cycles < 12) begin
      tick();
      cycles++;
    end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : -1;
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else       chk({tag, "_sum"}, 32'(sum), 32'(exp));
  endtask

  initial begin
    int  n;
    logic seen;

    rst = 1'b1; start = 1'b0; mask = 4'h0;
    set_ops(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_sel",  32'({S1, S0}), 32'd0);
    rst = 1'b0;
    tick();

    // 1: basic run, cycle-by-cycle selects and done timing
    set_ops(10, 20, 30, 40); mask = 4'b1111;
    sb_q.push_back(ref_sum(mask));
    start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_busy_c1", 32'(busy), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("t1_sel_c%0d", c + 1), 32'({S1, S0}), 32'(c));
      chk($sformatf("t1_done_c%0d", c + 1), 32'(done), 32'd0);
      tick();
    end
    chk("t1_done_c5", 32'(done), 32'd1);
    chk("t1_busy_c5", 32'(busy), 32'd1);
    chk("t1_sel_c5",  32'({S1, S0}), 32'd0);
    chk("t1_sum", 32'(sum), 32'(sb_q.pop_front()));
    tick();
    chk("t1_done_c6", 32'(done), 32'd0);
    chk("t1_busy_c6", 32'(busy), 32'd0);
    chk("t1_sum_hold", 32'(sum), 32'd100);

    // 2: all-max operands, no truncation
    set_ops(255, 255, 255, 255); mask = 4'b1111;
    sb_q.push_back(1020);
    start = 1'b1; tick(); start = 1'b0;
    wait_done("t2", n);
    chk("t2_latency", 32'(n), 32'd4);
    tick();

    // 3: partial mask, then empty mask
    set_ops(10, 20, 30, 40); mask = 4'b0101;
    sb_q.push_back(40);
    start = 1'b1; tick(); start = 1'b0;
    wait_done("t3a", n);
    tick();
    mask = 4'b0000;
    sb_q.push_back(0);
    start = 1'b1; tick(); start = 1'b0;
    wait_done("t3b", n);
    chk("t3b_done", 32'(done), 32'd1);
    tick();

    // 4: start held high, operands changed in each DONE cycle
    set_ops(1, 2, 3, 4); mask = 4'b1111;
    sb_q.push_back(ref_sum(mask));
    start = 1'b1;
    tick();
    wait_done("t4r1", n);
    set_ops(100, 50, 25, 5); mask = 4'b1011;
    sb_q.push_back(ref_sum(mask));
    tick();
    wait_done("t4r2", n);
    chk("t4_period2", 32'(n), 32'd5);
    set_ops(7, 0, 200, 9); mask = 4'b1110;
    sb_q.push_back(ref_sum(mask));
    tick();
    wait_done("t4r3", n);
    chk("t4_period3", 32'(n), 32'd5);
    start = 1'b0;
    tick(); tick();
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: reset while idx=2
    set_ops(10, 20, 30, 40); mask = 4'b1111;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("t5_sel_idx2", 32'({S1, S0}), 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_sum",  32'(sum),  32'd0);
    chk("t5_sel",  32'({S1, S0}), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("t5_no_done", 32'(seen), 32'd0);

    // 6: toggling start and mask mid-run uses the mask latched at accept
    set_ops(10, 20, 30, 40); mask = 4'b0101;
    sb_q.push_back(ref_sum(mask));
    start = 1'b1; tick();
    for (int c = 0; c < 3; c++) begin
      start = ~start; mask = ~mask;
      tick();
    end
    start = 1'b0;
    wait_done("t6", n);
    chk("t6_latency", 32'(n), 32'd1);
    tick();
    chk("t6_idle1", 32'(busy), 32'd0);
    tick();
    chk("t6_idle2", 32'(busy), 32'd0);
    chk("t6_sum_hold", 32'(sum), 32'd40);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
